// File: rtl/db_edge_multi.sv
// N-channel debounced edge detector: per channel a 2-FF synchroniser, polarity select,
// symmetric press/release debounce, registered level plus rise/fall/long-press ticks.
module db_edge_multi #(
  parameter int unsigned   N        = 2,
  parameter int unsigned   DB_CNT   = 10000,
  parameter int unsigned   LONG_CNT = 0,
  parameter logic [N-1:0]  INVERT   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button,
  output logic [N-1:0] level,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic [N-1:0] long_tick
);

  localparam int unsigned DW = $clog2(DB_CNT + 1);
  localparam int unsigned HW = (LONG_CNT == 0) ? 1 : $clog2(LONG_CNT + 1);

  localparam logic [DW-1:0] DbLast   = DW'(DB_CNT - 1);
  localparam logic [HW-1:0] HoldLast = HW'((LONG_CNT == 0) ? 0 : LONG_CNT - 1);

  localparam logic [1:0] StLow    = 2'd0;
  localparam logic [1:0] StWaitHi = 2'd1;
  localparam logic [1:0] StHigh   = 2'd2;
  localparam logic [1:0] StWaitLo = 2'd3;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          s;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          long_q, long_d;

    assign s = sync2_q ^ INVERT[i];

    always_comb begin
      sync1_d     = button[i];
      sync2_d     = sync1_q;
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      long_d      = 1'b0;
      case (state_q)
        StLow: begin
          if (s) begin
            state_d  = StWaitHi;
            db_cnt_d = '0;
          end
        end
        StWaitHi: begin
          if (!s) begin
            state_d = StLow;
          end else if (db_cnt_q == DbLast) begin
            state_d     = StHigh;
            rise_d      = 1'b1;
            level_d     = 1'b1;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
        StHigh: begin
          if (!s) begin
            state_d  = StWaitLo;
            db_cnt_d = '0;
          end else if (LONG_CNT != 0 && !long_done_q) begin
            // hold_cnt freezes once the long press has been reported
            if (hold_cnt_q == HoldLast) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
        end
        default: begin
          if (s) begin
            state_d = StHigh;
          end else if (db_cnt_q == DbLast) begin
            state_d = StLow;
            fall_d  = 1'b1;
            level_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DW'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        // idle inverted inputs must read as released straight out of reset
        sync1_q     <= INVERT[i];
        sync2_q     <= INVERT[i];
        state_q     <= StLow;
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        rise_q      <= rise_d;
        fall_q      <= fall_d;
        long_q      <= long_d;
      end
    end

    assign level[i]     = level_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;
    assign long_tick[i] = long_q;
  end

endmodule

// File: tb/tb_db_edge_multi.sv
// Bench for db_edge_multi: directed scenarios plus random button traffic, checked every cycle
// against a run-length debounce model.
module tb_db_edge_multi;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned LC = 10;
  localparam logic [1:0]  INV = 2'b10;

  logic         clk;
  logic         rst;
  logic [N-1:0] button;
  logic [N-1:0] level, rise_tick, fall_tick, long_tick;

  db_edge_multi #(
    .N        (N),
    .DB_CNT   (DB),
    .LONG_CNT (LC),
    .INVERT   (INV)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .level     (level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .long_tick (long_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference: raw delay line, run length of samples disagreeing with the level,
  // and number of stable-high samples since the last press.
  bit         m_d1 [N];
  bit         m_d2 [N];
  bit         m_lvl[N];
  bit         m_done[N];
  int         m_run[N];
  int         m_cnt[N];
  logic [1:0] e_lvl, e_rise, e_fall, e_long;

  int pc_rise[N];
  int pc_fall[N];
  int pc_long[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit s;
    bit in_high;
    e_rise = '0;
    e_fall = '0;
    e_long = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_d1[i] = INV[i]; m_d2[i] = INV[i];
        m_lvl[i] = 1'b0; m_done[i] = 1'b0; m_run[i] = 0; m_cnt[i] = 0;
      end else begin
        s       = m_d2[i] ^ INV[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = button[i];
        in_high = m_lvl[i] && (m_run[i] == 0);
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
              e_rise[i] = 1'b1; m_cnt[i] = 0; m_done[i] = 1'b0;
            end else begin
              e_fall[i] = 1'b1;
            end
          end
        end else begin
          if (in_high && !m_done[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == LC) begin
              e_long[i] = 1'b1; m_done[i] = 1'b1;
            end
          end
          m_run[i] = 0;
        end
      end
      e_lvl[i] = m_lvl[i];
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      check("outs", {24'b0, level, rise_tick, fall_tick, long_tick},
            {24'b0, e_lvl, e_rise, e_fall, e_long});
      for (int i = 0; i < N; i++) begin
        pc_rise[i] += int'(rise_tick[i]);
        pc_fall[i] += int'(fall_tick[i]);
        pc_long[i] += int'(long_tick[i]);
      end
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      pc_rise[i] = 0; pc_fall[i] = 0; pc_long[i] = 0;
    end
  endtask

  int rem[N];

  initial begin
    rst    = 1'b1;
    button = INV;
    cyc(2);
    check("reset_outs", {28'b0, level, rise_tick}, 32'h0);
    rst = 1'b0;
    cyc(5);

    // long press on ch0
    clr_counts();
    button[0] = 1'b1;
    cyc(30);
    check("t1_rise0", pc_rise[0], 1);
    check("t1_long0", pc_long[0], 1);
    check("t1_ch1",   pc_rise[1] + pc_fall[1] + pc_long[1], 0);
    button[0] = 1'b0;
    cyc(10);

    // pulse one short of qualifying, then exactly qualifying
    clr_counts();
    button[0] = 1'b1; cyc(4);
    button[0] = 1'b0; cyc(10);
    check("t2_short", pc_rise[0], 0);
    button[0] = 1'b1; cyc(5);
    button[0] = 1'b0; cyc(12);
    check("t2_rise", pc_rise[0], 1);
    check("t2_fall", pc_fall[0], 1);

    // release glitch while held
    clr_counts();
    button[0] = 1'b1; cyc(8);
    button[0] = 1'b0; cyc(3);
    button[0] = 1'b1; cyc(20);
    check("t3_nofall", pc_fall[0], 0);
    check("t3_long",   pc_long[0], 1);
    button[0] = 1'b0; cyc(10);

    // active-low channel
    clr_counts();
    button[1] = 1'b1; cyc(10);
    check("t4_idle", pc_rise[1], 0);
    button[1] = 1'b0; cyc(10);
    button[1] = 1'b1; cyc(10);
    check("t4_rise", pc_rise[1], 1);
    check("t4_fall", pc_fall[1], 1);

    // simultaneous press, single release
    clr_counts();
    button = 2'b01; cyc(8);
    button = 2'b00; cyc(10);
    check("t5_rise", pc_rise[0] + pc_rise[1], 2);
    check("t5_fall", {pc_fall[1][15:0], pc_fall[0][15:0]}, 32'h0000_0001);
    button = 2'b10; cyc(10);

    // reset while pressed
    clr_counts();
    button[0] = 1'b1; cyc(12);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(12);
    check("t6_rise",   pc_rise[0], 2);
    check("t6_nofall", pc_fall[0], 0);
    button[0] = 1'b0; cyc(10);

    // random traffic with occasional reset
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 25);
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          button[i] = ~button[i];
          rem[i]    = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30)
                                                  : $urandom_range(1, 8);
        end
      end
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
